// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive path: PID and error encodings,
// packet class decode and CRC polynomials.
package usb_pkg;

  typedef enum logic [3:0] {
    PidOut   = 4'b1000,
    PidIn    = 4'b1001,
    PidSetup = 4'b1011,
    PidData0 = 4'b1100,
    PidData1 = 4'b1101,
    PidAck   = 4'b0100,
    PidNak   = 4'b0101,
    PidStall = 4'b0111
  } pid_t;

  typedef enum logic [2:0] {
    ErrNone = 3'd0,
    ErrPid  = 3'd1,
    ErrLen  = 3'd2,
    ErrCrc  = 3'd3,
    ErrOvf  = 3'd4
  } err_t;

  typedef enum logic [1:0] {
    ClsNone,
    ClsToken,
    ClsData,
    ClsHs
  } pid_class_t;

  localparam logic [4:0]  Crc5Poly     = 5'b00101;
  localparam logic [15:0] Crc16Poly    = 16'h8005;
  localparam logic [4:0]  Crc5Residue  = 5'b01100;
  localparam logic [15:0] Crc16Residue = 16'h800D;

  // ClsNone covers both a bad check nibble and an unassigned PID.
  function automatic pid_class_t pid_class(input logic [7:0] pid_byte);
    pid_class_t cls;
    cls = ClsNone;
    if (pid_byte[7:4] == ~pid_byte[3:0]) begin
      case (pid_t'(pid_byte[7:4]))
        PidOut, PidIn, PidSetup: cls = ClsToken;
        PidData0, PidData1:      cls = ClsData;
        PidAck, PidNak, PidStall: cls = ClsHs;
        default:                 cls = ClsNone;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/crc_serial.sv
// Serial MSB-first LFSR CRC; clear loads all ones, enable shifts in one bit.
module crc_serial #(
  parameter int unsigned   W    = 5,
  parameter logic [W-1:0]  POLY = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         din_i,
  output logic [W-1:0] crc_o
);

  logic [W-1:0] crc_q, crc_d;
  logic         fb;

  always_comb begin
    fb    = din_i ^ crc_q[W-1];
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '1;
    end else if (en_i) begin
      crc_d = {crc_q[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) crc_q <= '1;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_rx_decoder.sv
// Decodes de-stuffed USB token, data and handshake packets into one registered
// result pulse per packet, with CRC5/CRC16 checking and payload capture.
module usb_rx_decoder import usb_pkg::*; #(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned DATA_W    = 8 * MAX_BYTES,
  parameter int unsigned CNT_W     = $clog2(8 * MAX_BYTES + 25)
) (
  input  logic                           clk,
  input  logic                           rst_L,
  input  logic                           recving,
  input  logic                           pause,
  input  logic                           inb,
  output logic [3:0]                     pid,
  output logic [6:0]                     addr,
  output logic [3:0]                     endp,
  output logic [DATA_W-1:0]              data,
  output logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
  output logic                           havetoken,
  output logic                           havepkt,
  output logic                           haveack,
  output logic                           havenak,
  output logic                           havestall,
  output logic                           error,
  output logic [2:0]                     err_code
);

  localparam int unsigned      NbW     = $clog2(MAX_BYTES + 1);
  localparam int unsigned      SrW     = DATA_W + 16;
  localparam logic [CNT_W-1:0] MaxBits = CNT_W'(8 + 8 * MAX_BYTES + 16);
  localparam logic [CNT_W-1:0] Cnt8    = CNT_W'(8);
  localparam logic [CNT_W-1:0] Cnt19   = CNT_W'(19);
  localparam logic [CNT_W-1:0] Cnt24   = CNT_W'(24);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         pid_sr_q;
  logic [SrW-1:0]     sr_q;
  logic               ovf_q;
  logic [3:0]         pid_q, endp_q;
  logic [6:0]         addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [NbW-1:0]     nbytes_q;
  logic [5:0]         flags_q;
  logic               error_q;
  err_t               err_code_q;

  logic               bit_ok, capture, shift_en;
  logic [4:0]         crc5;
  logic [15:0]        crc16;
  pid_class_t         cls;
  err_t               res_err;
  logic [CNT_W-1:0]   payload_bits;

  assign bit_ok   = recving & ~pause;
  assign capture  = bit_ok & (state_q != StRecv);
  assign shift_en = bit_ok & (state_q == StRecv) & (cnt_q != MaxBits);

  // CRC5 sees addr+endp only; CRC16 sees bits as they leave the 16-bit window.
  crc_serial #(.W(5), .POLY(Crc5Poly)) u_crc5 (
    .clk_i  (clk),
    .rst_ni (rst_L),
    .clr_i  (capture),
    .en_i   (shift_en && cnt_q >= Cnt8 && cnt_q < Cnt19),
    .din_i  (inb),
    .crc_o  (crc5)
  );

  crc_serial #(.W(16), .POLY(Crc16Poly)) u_crc16 (
    .clk_i  (clk),
    .rst_ni (rst_L),
    .clr_i  (capture),
    .en_i   (shift_en && cnt_q >= Cnt24),
    .din_i  (sr_q[15]),
    .crc_o  (crc16)
  );

  assign payload_bits = cnt_q - Cnt24;

  always_comb begin
    cls     = pid_class(pid_sr_q);
    res_err = ErrNone;
    if (cls == ClsNone) begin
      res_err = ErrPid;
    end else if (ovf_q) begin
      res_err = ErrOvf;
    end else begin
      unique case (cls)
        ClsToken: begin
          if (cnt_q != Cnt24)            res_err = ErrLen;
          else if (sr_q[4:0] != ~crc5)   res_err = ErrCrc;
        end
        ClsData: begin
          if (cnt_q < Cnt24 || cnt_q[2:0] != 3'd0) res_err = ErrLen;
          else if (sr_q[15:0] != ~crc16)           res_err = ErrCrc;
        end
        ClsHs: begin
          if (cnt_q != Cnt8) res_err = ErrLen;
        end
        default: res_err = ErrPid;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pid_sr_q   <= '0;
      sr_q       <= '0;
      ovf_q      <= 1'b0;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      data_q     <= '0;
      nbytes_q   <= '0;
      flags_q    <= '0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      flags_q    <= '0;
      error_q    <= 1'b0;
      err_code_q <= ErrNone;
      unique case (state_q)
        StIdle, StDone: begin
          if (bit_ok) begin
            state_q  <= StRecv;
            cnt_q    <= CNT_W'(1);
            pid_sr_q <= {7'b0, inb};
            sr_q     <= '0;
            ovf_q    <= 1'b0;
          end else begin
            state_q  <= StIdle;
          end
        end
        StRecv: begin
          if (!recving) begin
            state_q <= StDone;
            if (res_err != ErrNone) begin
              error_q    <= 1'b1;
              err_code_q <= res_err;
            end else begin
              pid_q <= pid_sr_q[7:4];
              unique case (cls)
                ClsToken: begin
                  flags_q[5] <= 1'b1;
                  addr_q     <= sr_q[15:9];
                  endp_q     <= sr_q[8:5];
                end
                ClsData: begin
                  flags_q[4] <= 1'b1;
                  data_q     <= sr_q[SrW-1:16];
                  nbytes_q   <= NbW'(payload_bits >> 3);
                end
                default: begin
                  flags_q[3] <= (pid_sr_q[7:4] == PidAck);
                  flags_q[2] <= (pid_sr_q[7:4] == PidNak);
                  flags_q[1] <= (pid_sr_q[7:4] == PidStall);
                end
              endcase
            end
          end else if (!pause) begin
            if (cnt_q == MaxBits) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q < Cnt8) pid_sr_q <= {pid_sr_q[6:0], inb};
              else              sr_q     <= {sr_q[SrW-2:0], inb};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pid       = pid_q;
  assign addr      = addr_q;
  assign endp      = endp_q;
  assign data      = data_q;
  assign nbytes    = nbytes_q;
  assign havetoken = flags_q[5];
  assign havepkt   = flags_q[4];
  assign haveack   = flags_q[3];
  assign havenak   = flags_q[2];
  assign havestall = flags_q[1];
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule
